// File: rtl/add_csv_accum_seq.sv
// Sequential multi-operand adder: accumulates a packet of operands in carry-save
// form, then resolves S+C CHUNK bits per cycle and hands the sum out over valid/ready.
module add_csv_accum_seq #(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     op_i,
    input  logic                 op_valid_i,
    input  logic                 op_last_i,
    output logic                 op_ready_o,
    output logic [WIDTH-1:0]     sum_o,
    output logic [CNT_WIDTH-1:0] n_ops_o,
    output logic                 sum_valid_o,
    input  logic                 sum_ready_i
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("add_csv_accum_seq: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {
        ACC = 2'd0,
        RES = 2'd1,
        OUT = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     s_reg;
    logic [WIDTH-1:0]     c_reg;
    logic [WIDTH-1:0]     res_reg;
    logic [WIDTH-1:0]     res_next;
    logic [WIDTH-1:0]     maj;
    logic [CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic                 accept;
    logic                 last_chunk;
    logic [CHUNK-1:0]     s_chunk;
    logic [CHUNK-1:0]     c_chunk;
    logic [CHUNK:0]       chunk_sum;

    assign op_ready_o  = (state == ACC);
    assign sum_valid_o = (state == OUT);
    assign accept      = op_valid_i && op_ready_o;
    assign last_chunk  = (idx == IDX_W'(NCHUNK - 1));
    assign maj         = (s_reg & c_reg) | (s_reg & op_i) | (c_reg & op_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACC:     if (accept && op_last_i) next_state = RES;
            RES:     if (last_chunk) next_state = OUT;
            OUT:     if (sum_ready_i) next_state = ACC;
            default: next_state = ACC;
        endcase
    end

    // One ripple slice of the final carry-propagate add, selected by idx
    always_comb begin
        s_chunk   = s_reg[idx*CHUNK +: CHUNK];
        c_chunk   = c_reg[idx*CHUNK +: CHUNK];
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, carry};
        res_next  = res_reg;
        res_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Resolution builds in res_reg so sum_o only changes when a new result is published
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_reg   <= '0;
            c_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            sum_o   <= '0;
            n_ops_o <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        s_reg <= s_reg ^ c_reg ^ op_i;
                        c_reg <= {maj[WIDTH-2:0], 1'b0};
                        if (cnt != {CNT_WIDTH{1'b1}}) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (op_last_i) begin
                            idx   <= '0;
                            carry <= 1'b0;
                        end
                    end
                end
                RES: begin
                    res_reg <= res_next;
                    carry   <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        idx     <= '0;
                        sum_o   <= res_next;
                        n_ops_o <= cnt;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (sum_ready_i) begin
                        s_reg <= '0;
                        c_reg <= '0;
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_csv_accum_seq.sv
// Randomized self-checking bench for add_csv_accum_seq; expected sums come from
// plain modular addition over the packet's operand list.
module tb_add_csv_accum_seq;

    localparam int WIDTH     = 8;
    localparam int CHUNK     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int NCHUNK    = WIDTH / CHUNK;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WIDTH-1:0]     op;
    logic                 op_valid;
    logic                 op_last;
    logic                 op_ready;
    logic [WIDTH-1:0]     sum;
    logic [CNT_WIDTH-1:0] n_ops;
    logic                 sum_valid;
    logic                 sum_ready;

    int check_count = 0;
    int pass_count  = 0;
    logic [WIDTH-1:0] pkt_ops[$];

    add_csv_accum_seq #(
        .WIDTH     (WIDTH),
        .CHUNK     (CHUNK),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op),
        .op_valid_i  (op_valid),
        .op_last_i   (op_last),
        .op_ready_o  (op_ready),
        .sum_o       (sum),
        .n_ops_o     (n_ops),
        .sum_valid_o (sum_valid),
        .sum_ready_i (sum_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] value, input logic last, input int gap_max);
        logic hs;
        int   waited;
        int   gaps;
        gaps     = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        op_valid = 1'b0;
        op_last  = 1'b0;
        repeat (gaps) begin
            op = WIDTH'($urandom);
            tick();
        end
        op_valid = 1'b1;
        op       = value;
        op_last  = last;
        hs       = 1'b0;
        waited   = 0;
        while (!hs && waited < 100) begin
            hs = op_ready;
            tick();
            waited++;
        end
        if (!hs) checkOutput("op_accept", {31'd0, hs}, 32'd1);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    // Sends pkt_ops, checks the published result, then stalls and consumes it
    task automatic applyStimulus(input int gap_max, input int stall, input bit pulse_ops);
        int unsigned total;
        logic [WIDTH-1:0] exp_sum;
        int exp_n;
        int lat;
        total = 0;
        foreach (pkt_ops[i]) total += pkt_ops[i];
        exp_sum = WIDTH'(total % (1 << WIDTH));
        exp_n   = (pkt_ops.size() > CNT_MAX) ? CNT_MAX : pkt_ops.size();

        foreach (pkt_ops[i]) send_op(pkt_ops[i], (i == pkt_ops.size() - 1), gap_max);

        lat = 0;
        while (!sum_valid && lat < 64) begin
            tick();
            lat++;
        end
        checkOutput("latency", lat, NCHUNK);
        checkOutput("sum", {24'd0, sum}, {24'd0, exp_sum});
        checkOutput("n_ops", {24'd0, n_ops}, exp_n);

        repeat (stall) begin
            if (pulse_ops) begin
                op_valid = 1'($urandom_range(1, 0));
                op       = WIDTH'($urandom);
                op_last  = 1'($urandom_range(1, 0));
            end
            tick();
            checkOutput("hold_valid", {31'd0, sum_valid}, 32'd1);
            checkOutput("hold_sum", {24'd0, sum}, {24'd0, exp_sum});
            checkOutput("hold_op_ready", {31'd0, op_ready}, 32'd0);
        end
        op_valid  = 1'b0;
        op_last   = 1'b0;
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        checkOutput("consumed", {31'd0, sum_valid}, 32'd0);
        checkOutput("op_ready_back", {31'd0, op_ready}, 32'd1);
        checkOutput("sum_kept", {24'd0, sum}, {24'd0, exp_sum});
    endtask

    initial begin
        bit seen_valid;
        int n;
        rst_n     = 1'b0;
        op        = '0;
        op_valid  = 1'b0;
        op_last   = 1'b0;
        sum_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rst_op_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        checkOutput("rst_sum", {24'd0, sum}, 32'd0);
        checkOutput("rst_n_ops", {24'd0, n_ops}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single operand and back-to-back packets");
        pkt_ops = '{8'h05};
        applyStimulus(0, 0, 1'b0);
        pkt_ops = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(0, 0, 1'b0);

        $display("[TB] wrap-around packets");
        pkt_ops = '{8'hFF, 8'h01, 8'h80, 8'h80};
        applyStimulus(0, 0, 1'b0);
        pkt_ops = '{8'hFF, 8'hFF, 8'hFF};
        applyStimulus(0, 1, 1'b0);

        $display("[TB] output backpressure with ignored operand pulses");
        pkt_ops = '{8'h21, 8'h42, 8'h07};
        applyStimulus(0, 5, 1'b1);
        pkt_ops = '{8'h03, 8'h04};
        applyStimulus(0, 0, 1'b0);

        $display("[TB] reset during resolution");
        send_op(8'h55, 1'b0, 0);
        send_op(8'h66, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_sum_valid", {31'd0, sum_valid}, 32'd0);
        checkOutput("midrst_op_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("midrst_sum", {24'd0, sum}, 32'd0);
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (NCHUNK + 3) begin
            tick();
            if (sum_valid) seen_valid = 1'b1;
        end
        checkOutput("midrst_no_result", {31'd0, seen_valid}, 32'd0);
        pkt_ops = '{8'h10, 8'h20};
        applyStimulus(0, 0, 1'b0);

        $display("[TB] random packets");
        for (int p = 0; p < 1000; p++) begin
            n = $urandom_range(20, 1);
            pkt_ops.delete();
            repeat (n) pkt_ops.push_back(WIDTH'($urandom));
            applyStimulus(2, $urandom_range(3, 0), 1'b1);
        end

        $display("[TB] counter saturation");
        pkt_ops.delete();
        repeat (300) pkt_ops.push_back(WIDTH'($urandom));
        applyStimulus(0, 0, 1'b0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
